fifo_write_ctrl: RTL and testbench
==================================

FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 Parameter ADDR_W, default 7, memory address width; depth 2^ADDR_W = 128.
REQ-003 Parameter AFULL_THRESH, default 120, fill level at which walmost_full asserts.
REQ-004 Parameter SYNC_STAGES, default 2, flop count of the read-pointer synchronizer; legal range 2..3.
REQ-005 clk  input  1  write-domain clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 winc  input  1  write request from producer.
REQ-008 w_rptr_gray  input  ADDR_W+1  Gray-coded read pointer, asynchronous (read domain).
REQ-009 wptr  output  ADDR_W+1  registered binary write pointer.
REQ-010 wptr_gray  output  ADDR_W+1  registered Gray write pointer, the only signal crossing to the read domain.
REQ-011 w_waddr  output  ADDR_W  memory write address = wptr[ADDR_W-1:0].
REQ-012 wen  output  1  memory write enable.
REQ-013 wfull  output  1  FIFO full.
REQ-014 walmost_full  output  1  fill level >= AFULL_THRESH.
REQ-015 wcount  output  ADDR_W+1  fill level as seen in the write domain, 0..128.
REQ-016 woverflow  output  1  sticky: a write was attempted while full.

Function
REQ-017 wen = winc && !wfull, combinational; the write is accepted on the same clk edge.
REQ-018 On an accepted write, wptr <= wptr+1 modulo 2^(ADDR_W+1) and wptr_gray <= bin2gray(wptr+1), both on the same edge.
REQ-019 winc while wfull: wptr and wptr_gray hold, and woverflow <= 1 and stays set until rst.
REQ-020 w_rptr_gray passes through SYNC_STAGES flops, then is converted Gray->binary into rptr_sync; no other logic touches the unsynchronized value.
REQ-021 wfull = (wptr[MSB] != rptr_sync[MSB]) && (wptr[ADDR_W-1:0] == rptr_sync[ADDR_W-1:0]), combinational from registers.
REQ-022 wcount = (wptr - rptr_sync) modulo 2^(ADDR_W+1), combinational; walmost_full = (wcount >= AFULL_THRESH).
REQ-023 Latency: a change on w_rptr_gray affects wfull/wcount exactly SYNC_STAGES edges later, so full is pessimistic and never optimistic.
REQ-024 Wrap-around: wptr 0xFF -> 0x00 and wptr_gray 0x80 -> 0x00; exactly one wptr_gray bit changes per accepted write.
REQ-025 Simultaneous accepted write and rptr_sync advance: both take effect, and wcount reflects the net change on the next cycle.

Reset
REQ-026 When rst=1 at a clk edge, wptr, wptr_gray, all synchronizer flops, and woverflow clear to 0; rst takes priority over winc.
REQ-027 After reset: w_waddr=0, wfull=0, wcount=0, walmost_full=0, wen=winc.
REQ-028 A reset mid-operation discards all pointer state; the read side is reset in the same system reset event.

Structure
REQ-029 Shared package cdc_fifo_pkg holds ADDR_W, PTR_W=ADDR_W+1, and the bin2gray and gray2bin functions, all reused by the read side.
REQ-030 One sub-module, ptr_sync (parameterised width and SYNC_STAGES flop chain), instantiated once for w_rptr_gray.
REQ-031 No memory array in this block; wen and w_waddr drive the shared dual-port RAM.

Verification
REQ-032 Reset with w_rptr_gray=0, then release -> wptr=0x00, wfull=0, wcount=0, woverflow=0.
REQ-033 128 consecutive winc with w_rptr_gray=0 -> walmost_full rises after the 120th write, wfull=1 and wcount=128 after the 128th, wptr=0x80.
REQ-034 129th winc while full -> wen=0, wptr stays 0x80, woverflow=1 and remains 1 after winc drops.
REQ-035 From full, drive w_rptr_gray=0x01 (binary 1) -> wfull still 1 for SYNC_STAGES-1 edges, then wfull=0 and wcount=127 at edge SYNC_STAGES.
REQ-036 Preset wptr=0xFF with the FIFO not full, then one write -> wptr=0x00, wptr_gray=0x00 from 0x80, and a single-bit Gray change is checked on every write.
REQ-037 Assert rst during a burst with wptr=0x35 -> all outputs at reset values the next cycle, and no wen in the reset cycle.

Source files
------------

// File: rtl/cdc_fifo_pkg.sv
// Shared pointer geometry and Gray/binary conversions for both sides of the async FIFO.
// Conversions are sized to PTR_W, so ADDR_W overrides on either side must match this package.
package cdc_fifo_pkg;

  localparam int ADDR_W = 7;
  localparam int PTR_W  = ADDR_W + 1;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer: output lags input by SYNC_STAGES edges.
// No handshake; every stage clears on synchronous reset.
module ptr_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side pointer/flag control of an async FIFO; writes accepted same edge, flags lag read pointer by SYNC_STAGES.
// Backpressure: wen drops while full; a write attempted while full sets sticky woverflow.
module fifo_write_ctrl #(
  parameter int ADDR_W       = cdc_fifo_pkg::ADDR_W,
  parameter int AFULL_THRESH = 120,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [ADDR_W:0]   w_rptr_gray,
  output logic [ADDR_W:0]   wptr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W-1:0] w_waddr,
  output logic              wen,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wcount,
  output logic              woverflow
);

  import cdc_fifo_pkg::*;

  localparam int              PW        = ADDR_W + 1;
  localparam logic [ADDR_W:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [ADDR_W:0] r_wptr;
  logic [ADDR_W:0] r_wptr_gray;
  logic            r_overflow;
  logic [ADDR_W:0] w_rptr_sync_gray;
  logic [ADDR_W:0] w_rptr_sync;
  logic [ADDR_W:0] w_wptr_inc;
  logic            w_full;
  logic            w_wen;

  ptr_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .i_d (w_rptr_gray),
    .o_q (w_rptr_sync_gray)
  );

  assign w_rptr_sync = gray2bin(w_rptr_sync_gray);
  assign w_wptr_inc  = r_wptr + PW'(1);

  assign w_full = (r_wptr[ADDR_W] != w_rptr_sync[ADDR_W]) &&
                  (r_wptr[ADDR_W-1:0] == w_rptr_sync[ADDR_W-1:0]);

  // The RAM must never see a write strobe in a cycle that is being reset.
  assign w_wen = winc && !w_full && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_wptr_gray <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wen) begin
        r_wptr      <= w_wptr_inc;
        r_wptr_gray <= bin2gray(w_wptr_inc);
      end
      if (winc && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign wptr         = r_wptr;
  assign wptr_gray    = r_wptr_gray;
  assign w_waddr      = r_wptr[ADDR_W-1:0];
  assign wen          = w_wen;
  assign wfull        = w_full;
  assign wcount       = r_wptr - w_rptr_sync;
  assign walmost_full = (wcount >= AFULL_LVL);
  assign woverflow    = r_overflow;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl with a queue-level reference model checked every cycle.
module tb_fifo_write_ctrl;

  localparam int AW = 7;
  localparam int SS = 2;
  localparam int AF = 120;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [7:0] w_rptr_gray;
  logic [7:0] wptr;
  logic [7:0] wptr_gray;
  logic [6:0] w_waddr;
  logic       wen;
  logic       wfull;
  logic       walmost_full;
  logic [7:0] wcount;
  logic       woverflow;

  always #5 clk = ~clk;

  fifo_write_ctrl #(
    .ADDR_W       (AW),
    .AFULL_THRESH (AF),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .w_rptr_gray  (w_rptr_gray),
    .wptr         (wptr),
    .wptr_gray    (wptr_gray),
    .w_waddr      (w_waddr),
    .wen          (wen),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: write count, sticky overflow, and a history of sampled read pointers.
  int m_wptr = 0;
  int m_ovf  = 0;
  int hist [SS];
  int m_full_now;
  bit m_valid    = 1'b0;
  bit m_last_rst = 1'b0;
  bit done       = 1'b0;

  function automatic int gdec(input int g);
    for (int b = 0; b < 256; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic int m_count();
    return (m_wptr - gdec(hist[SS-1])) & 255;
  endfunction

  function automatic logic [7:0] mg(input int b);
    return 8'((b ^ (b >> 1)) & 255);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_wptr = 0;
      m_ovf  = 0;
      for (int i = 0; i < SS; i++) hist[i] = 0;
      m_valid    = 1'b1;
      m_last_rst = 1'b1;
    end else begin
      m_full_now = (m_count() == 128) ? 1 : 0;
      if (winc && m_full_now == 0) m_wptr = (m_wptr + 1) & 255;
      if (winc && m_full_now == 1) m_ovf = 1;
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(w_rptr_gray);
      m_last_rst = 1'b0;
    end
  end

  logic [7:0] prev_g;
  bit         prev_ok = 1'b0;

  always @(negedge clk) begin
    if (m_valid && !done) begin
      chk("wptr",         wptr,         32'(m_wptr));
      chk("wptr_gray",    wptr_gray,    32'(mg(m_wptr)));
      chk("w_waddr",      w_waddr,      32'(m_wptr & 127));
      chk("wen",          wen,          32'(winc && (m_count() != 128) && !rst));
      chk("wfull",        wfull,        32'(m_count() == 128));
      chk("wcount",       wcount,       32'(m_count()));
      chk("walmost_full", walmost_full, 32'(m_count() >= AF));
      chk("woverflow",    woverflow,    32'(m_ovf));
      if (prev_ok && !m_last_rst && (wptr_gray !== prev_g))
        chk("gray_one_bit", 32'($countones(wptr_gray ^ prev_g)), 32'd1);
      prev_g  = wptr_gray;
      prev_ok = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    winc        = 1'b0;
    w_rptr_gray = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_wptr",  wptr,      32'h00);
    chk("rst_wfull", wfull,     32'd0);
    chk("rst_count", wcount,    32'd0);
    chk("rst_ovf",   woverflow, 32'd0);

    // Fill all 128 entries with the reader idle.
    winc = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      tick();
      if (i == 119) chk("afull_at_119", walmost_full, 32'd0);
      if (i == 120) chk("afull_at_120", walmost_full, 32'd1);
      if (i == 127) chk("full_at_127",  wfull,        32'd0);
    end
    chk("full_at_128",  wfull,  32'd1);
    chk("count_at_128", wcount, 32'd128);
    chk("wptr_at_128",  wptr,   32'h80);

    // Write attempt while full.
    chk("wen_when_full", wen, 32'd0);
    tick();
    chk("wptr_hold_full", wptr,      32'h80);
    chk("ovf_set",        woverflow, 32'd1);
    winc = 1'b0;
    tick();
    chk("ovf_sticky", woverflow, 32'd1);

    // Reader frees one entry; visible only after the synchronizer.
    w_rptr_gray = 8'h01;
    for (int e = 1; e < SS; e++) begin
      tick();
      chk("full_during_sync", wfull, 32'd1);
    end
    tick();
    chk("full_after_sync",  wfull,  32'd0);
    chk("count_after_sync", wcount, 32'd127);

    // Walk the write pointer to 0xFF with the reader trailing closely.
    winc = 1'b1;
    for (int k = 0; k < 400 && m_wptr != 255; k++) begin
      w_rptr_gray = mg((m_wptr + 254) & 255);
      tick();
    end
    chk("preset_wptr_ff", wptr,      32'hFF);
    chk("preset_gray_80", wptr_gray, 32'h80);
    tick();
    chk("wrap_wptr_00", wptr,      32'h00);
    chk("wrap_gray_00", wptr_gray, 32'h00);

    // Burst up to 0x35, then reset mid-burst.
    for (int k = 0; k < 400 && m_wptr != 8'h35; k++) begin
      w_rptr_gray = mg((m_wptr + 254) & 255);
      tick();
    end
    chk("burst_wptr_35", wptr, 32'h35);
    rst = 1'b1;
    #1;
    chk("no_wen_in_rst", wen, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_wptr",  wptr,         32'h00);
    chk("rst2_gray",  wptr_gray,    32'h00);
    chk("rst2_waddr", w_waddr,      32'h00);
    chk("rst2_full",  wfull,        32'd0);
    chk("rst2_count", wcount,       32'd0);
    chk("rst2_afull", walmost_full, 32'd0);
    chk("rst2_ovf",   woverflow,    32'd0);
    chk("rst2_wen",   wen,          32'd1);

    // Short burst after reset with the reader idle at zero.
    w_rptr_gray = 8'h00;
    repeat (5) tick();
    chk("post_rst_wptr", wptr, 32'h05);
    winc = 1'b0;
    tick();

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
